// File: rtl/seg7_scan_2digit_pkg.sv
// Shared constants for the 2-digit multiplexed 7-segment display stage.
// Segment patterns are active-high in g..a order (bit 0 = a); dp is not part of the pattern.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   localparam logic [1:0] S_BLANK0  = 2'd0;
   localparam logic [1:0] S_ONES_ON = 2'd1;
   localparam logic [1:0] S_BLANK1  = 2'd2;
   localparam logic [1:0] S_TENS_ON = 2'd3;

   function automatic logic is_on_state(input logic [1:0] s);
      return (s == S_ONES_ON) || (s == S_TENS_ON);
   endfunction

endpackage

// File: rtl/seg7_scan_2digit_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high g..a output.
// Codes 10-15 are not BCD and show a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_DASH;
      case (bcd)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed 7-segment driver with dead-time blanking and per-frame digit snapshot.
// All outputs are registered from next-state/next-snapshot so they move together with the FSM.
module seg7_scan_2digit
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned BLANK_CYC      = 500,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1,
   parameter bit          LZ_BLANK       = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       disp_en,
   input  logic [3:0] bcd_tens,
   input  logic [3:0] bcd_ones,
   output logic [7:0] seg,
   output logic [1:0] an,
   output logic       frame_tick
);

   localparam int unsigned TW = $clog2(SCAN_DIV);

   localparam logic [TW-1:0] ON_LAST    = TW'(SCAN_DIV - BLANK_CYC - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);

   localparam logic [7:0] SEG_DARK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [1:0] AN_DARK  = AN_ACTIVE_LOW  ? 2'b11 : 2'b00;

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nx;
   logic          slot_last;
   logic          frame_start;

   logic [3:0]    tens_q;
   logic [3:0]    ones_q;
   logic [3:0]    tens_nx;
   logic [3:0]    ones_nx;

   logic [3:0]    dec_in;
   logic [6:0]    dec_out;
   logic [6:0]    seg_lit;
   logic [1:0]    an_act;

   // ---------------- FSM + slot timer ----------------
   always_comb begin
      slot_last = is_on_state(state) ? (timer == ON_LAST) : (timer == BLANK_LAST);
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer + TW'(1);
      if (!disp_en) begin
         state_nx = S_BLANK0;
         timer_nx = '0;
      end else if (slot_last) begin
         timer_nx = '0;
         case (state)
            S_BLANK0:  state_nx = S_ONES_ON;
            S_ONES_ON: state_nx = S_BLANK1;
            S_BLANK1:  state_nx = S_TENS_ON;
            S_TENS_ON: state_nx = S_BLANK0;
            default:   state_nx = S_BLANK0;
         endcase
      end
   end

   always_comb begin
      frame_start = disp_en && (state == S_BLANK0) && slot_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_BLANK0;
         timer <= '0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
      end
   end

   // ---------------- Snapshot ----------------
   always_comb begin
      tens_nx = frame_start ? bcd_tens : tens_q;
      ones_nx = frame_start ? bcd_ones : ones_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_nx;
         ones_q <= ones_nx;
      end
   end

   // ---------------- Output stage ----------------
   // The single decoder sees the digit that the next state will display.
   always_comb begin
      dec_in = (state_nx == S_TENS_ON) ? tens_nx : ones_nx;
   end

   bcd_to_seg7 u_dec (
      .bcd     (dec_in),
      .pattern (dec_out)
   );

   always_comb begin
      seg_lit = SEG_OFF;
      an_act  = 2'b00;
      case (state_nx)
         S_ONES_ON: begin
            an_act  = 2'b01;
            seg_lit = dec_out;
         end
         S_TENS_ON: begin
            if (!(LZ_BLANK && (tens_nx == 4'd0))) begin
               an_act  = 2'b10;
               seg_lit = dec_out;
            end
         end
         default: begin
            an_act  = 2'b00;
            seg_lit = SEG_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_DARK;
         an         <= AN_DARK;
         frame_tick <= 1'b0;
      end else begin
         seg        <= SEG_ACTIVE_LOW ? ~{1'b0, seg_lit} : {1'b0, seg_lit};
         an         <= AN_ACTIVE_LOW ? ~an_act : an_act;
         frame_tick <= frame_start;
      end
   end

endmodule
